vga_sync_module: RTL and testbench

- Timing generator directly upstream of the VGA colour stage.
- Runs horizontal and vertical counters on the pixel clock and produces active-low HSYNC/VSYNC for the connector.
- Produces Ready_Sig and the 11-bit Column_Addr_Sig/Row_Addr_Sig that the colour stage uses to choose each pixel's colour.
- Default timing is 640x480@60 Hz with a 25 MHz pixel clock.

---
 rtl/vga_sync_module.sv | 115 +++++++++++
 tb/tb_vga_sync_module.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_module.sv
// VGA sync timing generator: hc/vc counters with registered sync, ready and address decode.
// Optional macro VGA_SYNC_ALIGN_EN delays HSYNC_Sig/VSYNC_Sig by one extra register stage.
module vga_sync_module #(
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FRONT  = 10
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        HSYNC_Sig,
    output logic        VSYNC_Sig,
    output logic        Ready_Sig,
    output logic [10:0] Column_Addr_Sig,
    output logic [10:0] Row_Addr_Sig,
    output logic        Frame_Start_Sig
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST      = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_SYNC_END  = 11'(H_SYNC);
    localparam logic [10:0] V_SYNC_END  = 11'(V_SYNC);
    localparam logic [10:0] H_ACT_START = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_ACT_END   = 11'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [10:0] V_ACT_START = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] V_ACT_END   = 11'(V_SYNC + V_BACK + V_ACTIVE);

    logic [10:0] hc;
    logic [10:0] vc;

    always_ff @(posedge CLK) begin
        if (RST) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? '0 : vc + 11'd1;
        end else begin
            hc <= hc + 11'd1;
        end
    end

    logic        hsync_d;
    logic        vsync_d;
    logic        ready_d;
    logic [10:0] col_d;
    logic [10:0] row_d;
    logic        fs_d;

    always_comb begin
        hsync_d = 1'b1;
        vsync_d = 1'b1;
        ready_d = 1'b0;
        col_d   = '0;
        row_d   = '0;
        fs_d    = 1'b0;
        if (hc < H_SYNC_END)
            hsync_d = 1'b0;
        if (vc < V_SYNC_END)
            vsync_d = 1'b0;
        if ((hc >= H_ACT_START) && (hc < H_ACT_END) &&
            (vc >= V_ACT_START) && (vc < V_ACT_END)) begin
            ready_d = 1'b1;
            col_d   = hc - H_ACT_START;
            row_d   = vc - V_ACT_START;
        end
        if ((hc == '0) && (vc == '0))
            fs_d = 1'b1;
    end

    logic hsync_q;
    logic vsync_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            hsync_q         <= 1'b1;
            vsync_q         <= 1'b1;
            Ready_Sig       <= 1'b0;
            Column_Addr_Sig <= '0;
            Row_Addr_Sig    <= '0;
            Frame_Start_Sig <= 1'b0;
        end else begin
            hsync_q         <= hsync_d;
            vsync_q         <= vsync_d;
            Ready_Sig       <= ready_d;
            Column_Addr_Sig <= col_d;
            Row_Addr_Sig    <= row_d;
            Frame_Start_Sig <= fs_d;
        end
    end

`ifdef VGA_SYNC_ALIGN_EN
    // Extra stage matches the colour stage's registered RGB latency.
    always_ff @(posedge CLK) begin
        if (RST) begin
            HSYNC_Sig <= 1'b1;
            VSYNC_Sig <= 1'b1;
        end else begin
            HSYNC_Sig <= hsync_q;
            VSYNC_Sig <= vsync_q;
        end
    end
`else
    assign HSYNC_Sig = hsync_q;
    assign VSYNC_Sig = vsync_q;
`endif

endmodule

// File: tb/tb_vga_sync_module.sv
// Directed bench for vga_sync_module: default 640x480 timing plus a tiny-timing instance for full frames.
module tb_vga_sync_module;

`ifdef VGA_SYNC_ALIGN_EN
    localparam int SL = 2;
`else
    localparam int SL = 1;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        HSYNC_Sig, VSYNC_Sig, Ready_Sig, Frame_Start_Sig;
    logic [10:0] Column_Addr_Sig, Row_Addr_Sig;
    logic        s_hsync, s_vsync, s_ready, s_fs;
    logic [10:0] s_col, s_row;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    always #5 CLK = ~CLK;

    vga_sync_module dut (
        .CLK(CLK), .RST(RST),
        .HSYNC_Sig(HSYNC_Sig), .VSYNC_Sig(VSYNC_Sig), .Ready_Sig(Ready_Sig),
        .Column_Addr_Sig(Column_Addr_Sig), .Row_Addr_Sig(Row_Addr_Sig),
        .Frame_Start_Sig(Frame_Start_Sig)
    );

    // 17 x 10 timing: frame of 170 cycles, 8x5 active area
    vga_sync_module #(
        .H_SYNC(4), .H_BACK(3), .H_ACTIVE(8), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(2), .V_ACTIVE(5), .V_FRONT(1)
    ) dut_s (
        .CLK(CLK), .RST(RST),
        .HSYNC_Sig(s_hsync), .VSYNC_Sig(s_vsync), .Ready_Sig(s_ready),
        .Column_Addr_Sig(s_col), .Row_Addr_Sig(s_row),
        .Frame_Start_Sig(s_fs)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_hsync"}, HSYNC_Sig, 1);
        chk({tag, "_vsync"}, VSYNC_Sig, 1);
        chk({tag, "_ready"}, Ready_Sig, 0);
        chk({tag, "_col"},   Column_Addr_Sig, 0);
        chk({tag, "_row"},   Row_Addr_Sig, 0);
        chk({tag, "_fs"},    Frame_Start_Sig, 0);
    endtask

    int h_low, v_low, fs_cnt, first_rdy;
    int s_rdy_cnt, s_vlow, s_fs_cnt;

    initial begin
        // Reset held for 5 cycles
        RST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_reset_vals("rst_hold");
        end
        chk("s_rst_ready", s_ready, 0);
        chk("s_rst_hsync", s_hsync, 1);

        // Release: counters are at (0,0) in cycle 0
        RST = 1'b0;
        cyc = 0;
        chk("c0_fs", Frame_Start_Sig, 0);
        chk("c0_hsync", HSYNC_Sig, 1);
        h_low = 0; v_low = 0; fs_cnt = 0; first_rdy = -1;
        s_rdy_cnt = 0; s_vlow = 0; s_fs_cnt = 0;

        while (cyc < 30000) begin
            step();
            if (cyc <= 800 && !HSYNC_Sig) h_low++;
            if (cyc <= 2000 && !VSYNC_Sig) v_low++;
            if (Frame_Start_Sig) fs_cnt++;
            if (Ready_Sig && first_rdy < 0) first_rdy = cyc;
            if (cyc <= 170 && s_ready) s_rdy_cnt++;
            if (cyc <= 170 && !s_vsync) s_vlow++;
            if (cyc <= 400 && s_fs) s_fs_cnt++;

            if (cyc == 1)           chk("c1_fs", Frame_Start_Sig, 1);
            if (cyc == 2)           chk("c2_fs", Frame_Start_Sig, 0);
            if (cyc == SL - 1)      chk("h_pre", HSYNC_Sig, 1);
            if (cyc == SL)          chk("h_first_low", HSYNC_Sig, 0);
            if (cyc == 95 + SL)     chk("h_last_low", HSYNC_Sig, 0);
            if (cyc == 96 + SL)     chk("h_after", HSYNC_Sig, 1);
            if (cyc == 799 + SL)    chk("h_line2_pre", HSYNC_Sig, 1);
            if (cyc == 800 + SL)    chk("h_line2_low", HSYNC_Sig, 0);
            if (cyc == 1599 + SL)   chk("v_last_low", VSYNC_Sig, 0);
            if (cyc == 1600 + SL)   chk("v_after", VSYNC_Sig, 1);
            if (cyc == 28144) begin
                chk("r_pre", Ready_Sig, 0);
                chk("r_pre_col", Column_Addr_Sig, 0);
            end
            if (cyc == 28145) begin
                chk("r_first", Ready_Sig, 1);
                chk("r_first_col", Column_Addr_Sig, 0);
                chk("r_first_row", Row_Addr_Sig, 0);
            end
            if (cyc == 28784) begin
                chk("r_end", Ready_Sig, 1);
                chk("r_end_col", Column_Addr_Sig, 639);
                chk("r_end_row", Row_Addr_Sig, 0);
            end
            if (cyc == 28785) begin
                chk("r_post", Ready_Sig, 0);
                chk("r_post_col", Column_Addr_Sig, 0);
            end
            if (cyc == 28945) begin
                chk("r_row1", Ready_Sig, 1);
                chk("r_row1_row", Row_Addr_Sig, 1);
            end
            // Small instance: first active at cycle 76, last at 151, second frame at 171
            if (cyc == 75)  chk("s_pre", s_ready, 0);
            if (cyc == 76) begin
                chk("s_first", s_ready, 1);
                chk("s_first_col", s_col, 0);
                chk("s_first_row", s_row, 0);
            end
            if (cyc == 151) begin
                chk("s_last", s_ready, 1);
                chk("s_last_col", s_col, 7);
                chk("s_last_row", s_row, 4);
            end
            if (cyc == 152) chk("s_after_last", s_ready, 0);
            if (cyc == 170) chk("s_fs_170", s_fs, 0);
            if (cyc == 171) chk("s_fs_171", s_fs, 1);
            if (cyc == 341) chk("s_fs_341", s_fs, 1);
        end

        chk("h_low_cnt", h_low, 96);
        chk("v_low_cnt", v_low, 1600);
        chk("fs_cnt", fs_cnt, 1);
        chk("first_rdy", first_rdy, 28145);
        chk("s_rdy_cnt", s_rdy_cnt, 40);
        chk("s_vlow_cnt", s_vlow, 34);
        chk("s_fs_cnt", s_fs_cnt, 3);

        // Counters now at hc=400, vc=37: mid active area
        chk("mid_ready", Ready_Sig, 1);
        chk("mid_col", Column_Addr_Sig, 255);
        chk("mid_row", Row_Addr_Sig, 2);
        RST = 1'b1;
        step();
        chk_reset_vals("mid_rst");
        RST = 1'b0;
        cyc = 0;
        h_low = 0; fs_cnt = 0;
        chk("m0_fs", Frame_Start_Sig, 0);
        while (cyc < 1000) begin
            step();
            if (cyc <= 800 && !HSYNC_Sig) h_low++;
            if (Frame_Start_Sig) fs_cnt++;
            if (cyc == 1)        chk("m1_fs", Frame_Start_Sig, 1);
            if (cyc == 2)        chk("m2_fs", Frame_Start_Sig, 0);
            if (cyc == SL - 1)   chk("m_h_pre", HSYNC_Sig, 1);
            if (cyc == SL)       chk("m_h_first_low", HSYNC_Sig, 0);
            if (cyc == 95 + SL)  chk("m_h_last_low", HSYNC_Sig, 0);
            if (cyc == 96 + SL)  chk("m_h_after", HSYNC_Sig, 1);
            if (cyc == 800 + SL) chk("m_h_line2_low", HSYNC_Sig, 0);
        end
        chk("m_h_low_cnt", h_low, 96);
        chk("m_fs_cnt", fs_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
